// File: rtl/command_tx_buf_pkg.sv
// Shared defaults and FSM encoding for the command-layer transmit buffer.
package command_tx_buf_pkg;

  localparam int unsigned AW_DEF     = 10;
  localparam int unsigned LEN_W_DEF  = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/command_tx_ram.sv
// Simple dual-port 2^AW x DW RAM, synchronous read with one cycle of latency.
module command_tx_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage array carries no reset; the buffer tracks validity by its count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/command_tx_buf.sv
// SATA command-layer write buffer: AL pushes dwords, the block frames exactly
// tx_len_in of them towards the transport layer with a val/strobe handshake.
module command_tx_buf
  import command_tx_buf_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       al_data_in,
  input  logic              al_data_val_in,
  output logic              al_data_full_out,
  output logic [AW:0]       al_data_cnt_out,
  output logic              al_overflow_out,
  input  logic              al_flush_in,
  input  logic              tx_start_in,
  input  logic [LEN_W-1:0]  tx_len_in,
  input  logic              tx_abort_in,
  output logic              tx_busy_out,
  output logic              tx_done_out,
  output logic [31:0]       tl_data_out,
  output logic              tl_data_val_out,
  output logic              tl_data_last_out,
  input  logic              tl_data_strobe_in
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  tx_state_e           state_q, state_d;
  logic [AW-1:0]       waddr_q, raddr_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_q, ovf_q, busy_q, zero_done_q;
  logic [LEN_W-1:0]    remaining_q, reads_left_q;
  logic                inflight_q;
  logic [1:0]          skid_cnt_q;
  logic [DATA_W-1:0]   skid0_q, skid1_q;
  logic [DATA_W-1:0]   ram_rdata;

  logic                kill, wr, rd, pop, val, start_ok, len_zero;
  logic                fsm_stream, fsm_done;
  logic [2:0]          occ;

  assign kill     = al_flush_in | tx_abort_in;
  assign wr       = al_data_val_in & ~full_q & ~al_flush_in;
  assign val      = (skid_cnt_q != 2'd0);
  assign pop      = val & tl_data_strobe_in & fsm_stream;
  assign start_ok = (state_q == ST_IDLE) & tx_start_in & ~kill;
  assign len_zero = (tx_len_in == '0);

  // The dword leaving the skid this cycle frees its slot, which keeps 1 dword/clk.
  assign occ = 3'(skid_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign rd  = fsm_stream & (cnt_q != '0) & (reads_left_q != '0) & (occ < 3'd2) & ~kill;

  assign cnt_d = al_flush_in ? '0 : (cnt_q + CW'(wr) - CW'(rd));

  command_tx_ram #(.AW(AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (waddr_q),
    .wdata (al_data_in),
    .re    (rd),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  // Write side: pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(DEPTH));
      if (wr) waddr_q <= waddr_q + AW'(1);
      if (al_flush_in)  raddr_q <= waddr_q;
      else if (rd)      raddr_q <= raddr_q + AW'(1);
      if (al_flush_in)                     ovf_q <= 1'b0;
      else if (al_data_val_in && full_q)   ovf_q <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort and flush override everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok && !len_zero) state_d = ST_STREAM;
      ST_STREAM: if (pop && remaining_q == LEN_W'(1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end

  // State decode
  always_comb begin
    fsm_stream = 1'b0;
    fsm_done   = 1'b0;
    case (state_q)
      ST_STREAM: fsm_stream = 1'b1;
      ST_DONE:   fsm_done   = 1'b1;
      default:   ;
    endcase
  end

  // Transfer bookkeeping: dwords still to hand over and RAM reads still allowed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining_q  <= '0;
      reads_left_q <= '0;
      zero_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      zero_done_q <= start_ok & len_zero;
      busy_q      <= (state_d != ST_IDLE);
      if (kill) begin
        remaining_q  <= '0;
        reads_left_q <= '0;
      end else if (start_ok && !len_zero) begin
        remaining_q  <= tx_len_in;
        reads_left_q <= tx_len_in;
      end else begin
        if (pop) remaining_q  <= remaining_q - LEN_W'(1);
        if (rd)  reads_left_q <= reads_left_q - LEN_W'(1);
      end
    end
  end

  // Two-entry skid; the head register holds its value when the queue drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
      inflight_q <= 1'b0;
    end else if (kill) begin
      skid_cnt_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd;
      if (pop && skid_cnt_q == 2'd2) skid0_q <= skid1_q;
      if (inflight_q) begin
        if ((skid_cnt_q - 2'(pop)) == 2'd0) skid0_q <= ram_rdata;
        else                                skid1_q <= ram_rdata;
      end
      skid_cnt_q <= skid_cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end

  assign al_data_full_out = full_q;
  assign al_data_cnt_out  = cnt_q;
  assign al_overflow_out  = ovf_q;
  assign tx_busy_out      = busy_q;
  assign tx_done_out      = fsm_done | zero_done_q;
  assign tl_data_out      = skid0_q;
  assign tl_data_val_out  = val;
  assign tl_data_last_out = val & (remaining_q == LEN_W'(1));

endmodule
